// File: rtl/mips_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package mips_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pc;
  } fetch_entry_t;

  // Sequential PC of the next word; wraps modulo 2^32.
  function automatic logic [INSTR_W-1:0] pc_next(input logic [INSTR_W-1:0] pc);
    return pc + INSTR_W'(WORD_BYTES);
  endfunction

  // PC of the request issued `words` fetches before `pc`.
  function automatic logic [INSTR_W-1:0] pc_back(input logic [INSTR_W-1:0] pc,
                                                 input logic [INSTR_W-1:0] words);
    return pc - (words << 2);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {instr, pc} entries with flush; head is read combinationally.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  fetch_entry_t     i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output fetch_entry_t     o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A pop frees the slot a same-cycle push lands in when full.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush && !rst) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// PC owner and fetch issue/collect stage with redirect flush and in-flight drain.
// Optional feature macro: MISALIGN_TRAP_EN (sticky misaligned-redirect trap that halts fetch).
module fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned        DEPTH    = 4,
  parameter logic [INSTR_W-1:0] RESET_PC = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [INSTR_W-1:0] imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [INSTR_W-1:0] redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [INSTR_W-1:0] out_pc,
  output logic [INSTR_W-1:0] out_pc_plus4,
  output logic               misalign_err
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic [INSTR_W-1:0] r_fetch_pc;
  logic [INSTR_W-1:0] w_fetch_pc_nxt;
  logic [CNT_W-1:0]   r_outstanding;
  logic [CNT_W-1:0]   w_outstanding_nxt;

  logic               w_credit;
  logic               w_halt;
  logic               w_accept;
  logic               w_rsp_take;
  logic [INSTR_W-1:0] w_rsp_pc;
  logic [INSTR_W-1:0] w_redirect_pc;
  logic               w_push;
  logic               w_pop;
  logic               w_flush;
  fetch_entry_t       w_push_data;
  fetch_entry_t       w_head;
  logic [CNT_W-1:0]   w_count;
  logic               w_fifo_full;
  logic               w_fifo_empty;

`ifdef MISALIGN_TRAP_EN
  logic r_misalign;

  assign w_redirect_pc = redirect_pc;
  assign w_halt        = r_misalign;
  assign misalign_err  = r_misalign && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      r_misalign <= 1'b1;
    end
  end
`else
  logic w_unused_pc_lsb;

  assign w_unused_pc_lsb = ^redirect_pc[1:0];
  assign w_redirect_pc   = {redirect_pc[INSTR_W-1:2], 2'b00};
  assign w_halt          = 1'b0;
  assign misalign_err    = 1'b0;
`endif

  // Credit covers both in-flight and buffered words so a response always has a slot.
  assign w_credit       = (SUM_W'(r_outstanding) + SUM_W'(w_count)) < SUM_W'(DEPTH);
  assign imem_req_valid = !rst && (r_state == RUN) && w_credit && !w_halt;
  assign imem_req_addr  = r_fetch_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign w_rsp_take     = imem_rsp_valid && (r_outstanding != '0);
  assign w_rsp_pc       = pc_back(r_fetch_pc, INSTR_W'(r_outstanding));

  assign w_push_data.instr = imem_rsp_data;
  assign w_push_data.pc    = w_rsp_pc;

  assign out_valid    = !rst && !w_fifo_empty;
  assign out_instr    = w_head.instr;
  assign out_pc       = w_head.pc;
  assign out_pc_plus4 = pc_next(w_head.pc);

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_outstanding <= w_outstanding_nxt;
    end
  end

  // Redirect beats push/pop; a request accepted alongside it stays in flight and is drained.
  always_comb begin
    w_state_nxt       = r_state;
    w_fetch_pc_nxt    = r_fetch_pc;
    w_outstanding_nxt = r_outstanding + CNT_W'(w_accept) - CNT_W'(w_rsp_take);
    w_push            = 1'b0;
    w_pop             = 1'b0;
    w_flush           = 1'b0;

    if (w_accept) w_fetch_pc_nxt = pc_next(r_fetch_pc);

    if (redirect_valid) begin
      w_flush        = 1'b1;
      w_fetch_pc_nxt = w_redirect_pc;
      w_state_nxt    = (w_outstanding_nxt != '0) ? DRAIN : RUN;
    end else begin
      case (r_state)
        RUN: begin
          w_push = w_rsp_take;
          w_pop  = out_valid && out_ready;
        end
        DRAIN: begin
          if (w_outstanding_nxt == '0) w_state_nxt = RUN;
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && w_fifo_full && !w_pop));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirect/drain, wrap, reset and misalign.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc, out_pc_plus4;
  logic        misalign_err;
  logic        rsp_en;

  logic        w_rst, w_req_valid, w_out_valid, w_mis;
  logic        w_one = 1'b1, w_zero = 1'b0;
  logic [31:0] w_req_addr, w_instr, w_pc, w_pc4, w_zero32 = 32'h0;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mem_q[$];
  logic [31:0] acc_log[$];
  logic [31:0] wrap_log[$];

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .misalign_err(misalign_err)
  );

  fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(w_rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_one), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_zero), .imem_rsp_data(w_zero32),
    .redirect_valid(w_zero), .redirect_pc(w_zero32),
    .out_valid(w_out_valid), .out_ready(w_zero), .out_instr(w_instr),
    .out_pc(w_pc), .out_pc_plus4(w_pc4), .misalign_err(w_mis)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction

  // Memory: in-order responses one cycle after accept, released only while rsp_en is set.
  always begin
    @(negedge clk); #3;
    if (rsp_en && mem_q.size() > 0) begin
      rsp_valid = 1'b1;
      rsp_data  = mem_word(mem_q.pop_front());
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = 32'h0;
    end
    if (req_valid && req_ready) begin
      mem_q.push_back(req_addr);
      acc_log.push_back(req_addr);
    end
    if (w_req_valid) wrap_log.push_back(w_req_addr);
  end

  task automatic cyc();
    @(negedge clk); #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_ready = 1'b0; rsp_en = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; out_ready = 1'b0;
    cyc();
    mem_q.delete(); acc_log.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; w_rst = 1'b1; req_ready = 1'b0; rsp_en = 1'b0; rsp_valid = 1'b0;
    rsp_data = 32'h0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    cyc();
    vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid: got %b want 0", req_valid); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (misalign_err !== 1'b0) begin miscompares++; $display("FAIL reset_misalign: got %b want 0", misalign_err); end
    rst = 1'b0; w_rst = 1'b0;
    cyc();
    vectors++; if (req_valid !== 1'b1) begin miscompares++; $display("FAIL reset_first_req: got %b want 1", req_valid); end
    vectors++; if (req_addr !== 32'h0) begin miscompares++; $display("FAIL reset_first_addr: got %h want 00000000", req_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    int pops;
    int first_i;
    do_reset();
    req_ready = 1'b1; rsp_en = 1'b1; out_ready = 1'b1;
    exp_pc = 32'h0; pops = 0; first_i = -1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (out_valid) begin
        if (first_i < 0) first_i = i;
        vectors++; if (out_pc !== exp_pc) begin miscompares++; $display("FAIL stream_pc: got %h want %h", out_pc, exp_pc); end
        vectors++; if (out_instr !== mem_word(exp_pc)) begin miscompares++; $display("FAIL stream_instr: got %h want %h", out_instr, mem_word(exp_pc)); end
        vectors++; if (out_pc_plus4 !== exp_pc + 32'd4) begin miscompares++; $display("FAIL stream_pc4: got %h want %h", out_pc_plus4, exp_pc + 32'd4); end
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
    end
    vectors++; if (first_i !== 1) begin miscompares++; $display("FAIL stream_latency: got %0d want 1", first_i); end
    vectors++; if (pops !== 11) begin miscompares++; $display("FAIL stream_rate: got %0d want 11", pops); end
  endtask

  task automatic test_backpressure();
    do_reset();
    req_ready = 1'b1; rsp_en = 1'b1; out_ready = 1'b0;
    repeat (10) cyc();
    vectors++; if (acc_log.size() !== 4) begin miscompares++; $display("FAIL bp_accepts: got %0d want 4", acc_log.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < acc_log.size()) begin
        vectors++; if (acc_log[i] !== 32'(i * 4)) begin miscompares++; $display("FAIL bp_addr%0d: got %h want %h", i, acc_log[i], 32'(i * 4)); end
      end
    end
    vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("FAIL bp_stall: got %b want 0", req_valid); end
    vectors++; if (out_pc !== 32'h0) begin miscompares++; $display("FAIL bp_head: got %h want 00000000", out_pc); end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    vectors++; if (req_valid !== 1'b1) begin miscompares++; $display("FAIL bp_resume: got %b want 1", req_valid); end
    vectors++; if (req_addr !== 32'h10) begin miscompares++; $display("FAIL bp_resume_addr: got %h want 00000010", req_addr); end
    cyc();
    vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("FAIL bp_restall: got %b want 0", req_valid); end
    vectors++; if (out_pc !== 32'h4) begin miscompares++; $display("FAIL bp_head2: got %h want 00000004", out_pc); end
  endtask

  task automatic wait_first_out(input string name, input logic [31:0] exp_pc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      cyc();
      if (out_valid) begin
        seen = 1'b1;
        vectors++; if (out_pc !== exp_pc) begin miscompares++; $display("FAIL %s_pc: got %h want %h", name, out_pc, exp_pc); end
        vectors++; if (out_instr !== mem_word(exp_pc)) begin miscompares++; $display("FAIL %s_instr: got %h want %h", name, out_instr, mem_word(exp_pc)); end
        vectors++; if (out_pc_plus4 !== exp_pc + 32'd4) begin miscompares++; $display("FAIL %s_pc4: got %h want %h", name, out_pc_plus4, exp_pc + 32'd4); end
      end
    end
    if (!seen) begin vectors++; miscompares++; $display("FAIL %s_timeout: got no out_valid want pc %h", name, exp_pc); end
  endtask

  task automatic test_redirect();
    do_reset();
    req_ready = 1'b1; out_ready = 1'b1;
    cyc(); cyc();
    req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    cyc();
    redirect_valid = 1'b0;
    vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("FAIL redir_drain_req: got %b want 0", req_valid); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL redir_flush: got %b want 0", out_valid); end
    acc_log.delete();
    req_ready = 1'b1; rsp_en = 1'b1;
    wait_first_out("redir", 32'h40);
    vectors++; if (acc_log.size() == 0 || acc_log[0] !== 32'h40) begin miscompares++; $display("FAIL redir_fetch: got %0d entries want first 00000040", acc_log.size()); end
  endtask

  task automatic test_drain_redirect();
    do_reset();
    req_ready = 1'b1; out_ready = 1'b1;
    cyc(); cyc();
    req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    cyc();
    redirect_pc = 32'h200;
    vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("FAIL drain2_req_a: got %b want 0", req_valid); end
    cyc();
    redirect_valid = 1'b0;
    vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("FAIL drain2_req_b: got %b want 0", req_valid); end
    req_ready = 1'b1; rsp_en = 1'b1;
    wait_first_out("drain2", 32'h200);
  endtask

  task automatic test_wrap();
    vectors++; if (wrap_log.size() !== 4) begin miscompares++; $display("FAIL wrap_count: got %0d want 4", wrap_log.size()); end
    if (wrap_log.size() >= 3) begin
      vectors++; if (wrap_log[0] !== 32'hFFFF_FFF8) begin miscompares++; $display("FAIL wrap_a0: got %h want fffffff8", wrap_log[0]); end
      vectors++; if (wrap_log[1] !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_a1: got %h want fffffffc", wrap_log[1]); end
      vectors++; if (wrap_log[2] !== 32'h0000_0000) begin miscompares++; $display("FAIL wrap_a2: got %h want 00000000", wrap_log[2]); end
    end
  endtask

  task automatic test_rst_midflight();
    do_reset();
    req_ready = 1'b1; out_ready = 1'b1;
    cyc(); cyc(); cyc();
    vectors++; if (mem_q.size() !== 3) begin miscompares++; $display("FAIL rstm_inflight: got %0d want 3", mem_q.size()); end
    rst = 1'b1; req_ready = 1'b0;
    cyc();
    vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("FAIL rstm_req: got %b want 0", req_valid); end
    rst = 1'b0; rsp_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstm_late%0d: got %b want 0", i, out_valid); end
    end
    vectors++; if (req_addr !== 32'h0) begin miscompares++; $display("FAIL rstm_pc: got %h want 00000000", req_addr); end
    acc_log.delete();
    req_ready = 1'b1;
    wait_first_out("rstm", 32'h0);
  endtask

  task automatic test_misalign();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    cyc();
    redirect_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
    vectors++; if (misalign_err !== 1'b1) begin miscompares++; $display("FAIL mis_set: got %b want 1", misalign_err); end
    req_ready = 1'b1;
    repeat (3) cyc();
    vectors++; if (req_valid !== 1'b0) begin miscompares++; $display("FAIL mis_halt: got %b want 0", req_valid); end
    vectors++; if (acc_log.size() !== 0) begin miscompares++; $display("FAIL mis_noreq: got %0d want 0", acc_log.size()); end
    vectors++; if (misalign_err !== 1'b1) begin miscompares++; $display("FAIL mis_sticky: got %b want 1", misalign_err); end
    req_ready = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    vectors++; if (misalign_err !== 1'b0) begin miscompares++; $display("FAIL mis_clear: got %b want 0", misalign_err); end
    vectors++; if (req_valid !== 1'b1 || req_addr !== 32'h0) begin miscompares++; $display("FAIL mis_restart: got %b/%h want 1/00000000", req_valid, req_addr); end
`else
    vectors++; if (misalign_err !== 1'b0) begin miscompares++; $display("FAIL mis_tied: got %b want 0", misalign_err); end
    vectors++; if (req_valid !== 1'b1) begin miscompares++; $display("FAIL mis_req: got %b want 1", req_valid); end
    vectors++; if (req_addr !== 32'h40) begin miscompares++; $display("FAIL mis_align: got %h want 00000040", req_addr); end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_drain_redirect();
    test_wrap();
    test_rst_midflight();
    test_misalign();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
